button_ctrl_nch: RTL



---
 rtl/button_ctrl_nch_pkg.sv | 21 ++
 rtl/button_ctrl_nch_debounce.sv | 65 ++++++
 rtl/button_ctrl_nch.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/button_ctrl_nch_pkg.sv
// Shared encodings for the multi-channel button controller.
// No logic. The FSM states, button indices and step sizes are used by the top module and the bench.
// No flow control.
package button_ctrl_nch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD_UP = 2'd1,
    ST_HOLD_DN = 2'd2,
    ST_CHORD   = 2'd3
  } state_e;

  localparam int BTN_UP_IDX  = 0;
  localparam int BTN_DN_IDX  = 1;
  localparam int BTN_SEL_IDX = 2;
  localparam int NBTN        = 3;

  localparam int STEP_X1  = 1;
  localparam int STEP_X10 = 10;

endpackage

// File: rtl/button_ctrl_nch_debounce.sv
// Per-button 2-FF synchroniser plus stable timer. Outputs the debounced level and press/release pulses.
// Latency: 2 sync cycles plus DB_TIMEOUT stable cycles. The level and pulses are registered.
// No backpressure. Pulses are single-cycle and are not held.
module btn_debounce #(
  parameter int DBW        = 15,
  parameter int DB_TIMEOUT = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,      // raw, active-low, asynchronous
  output logic sync_lvl,   // synchronised raw level
  output logic lvl,        // debounced level (1 = released)
  output logic press_pls,  // debounced 1->0
  output logic rel_pls     // debounced 0->1
);

  logic           sync1_q, sync2_q;
  logic           lvl_q, lvl_d;
  logic           press_q, press_d;
  logic           rel_q, rel_d;
  logic [DBW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles of disagreement and flip the level once the count reaches the timeout.
  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == DBW'(DB_TIMEOUT - 1)) begin
        lvl_d   = sync2_q;
        press_d = ~sync2_q;
        rel_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + DBW'(1);
      end
    end
  end

  // Sync flops reset to the pressed state. This keeps a button that is held through reset
  // reading as pressed until it is really released (see the blocking logic in the top module).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_lvl  = sync2_q;
  assign lvl       = lvl_q;
  assign press_pls = press_q;
  assign rel_pls   = rel_q;

endmodule

// File: rtl/button_ctrl_nch.sv
// Debounced 3-button control of NCH bounded counters, with x1/x10 chord toggle, auto-repeat and channel select.
// Latency: a debounced press pulse in cycle t updates CNT, CHG and CLR_SEQ at edge t+1.
// No backpressure. Buttons are sampled freely. A UBND change clamps the counters on the next edge.
module button_ctrl_nch
  import button_ctrl_nch_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int CW         = 8,
  parameter int DBW        = 15,
  parameter int DB_TIMEOUT = 20000,
  parameter int RPT_DLY    = 500000,
  parameter int RPT_PER    = 100000,
  parameter int CLR_CYC    = 2047,
  parameter int WRAP       = 0
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic                                     BTN_UP,
  input  logic                                     BTN_DN,
  input  logic                                     BTN_SEL,
  input  logic [NCH*CW-1:0]                        UBND,
  output logic [NCH*CW-1:0]                        CNT,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] CH_SEL,
  output logic                                     STEP10,
  output logic [NCH-1:0]                           CHG,
  output logic                                     CLR_SEQ
);

  localparam int CSW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RTW = $clog2(((RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER) + 1);
  localparam int CLW = $clog2(CLR_CYC + 1);

  logic [NBTN-1:0] btn_raw, sync_lvl, lvl, press, rel, press_ok;
  logic [NBTN-1:0] blk_q, blk_d;
  logic            unused_sel;

  state_e                   state_q, state_d;
  logic [NCH-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [CSW-1:0]           ch_sel_q, ch_sel_d;
  logic                     step10_q, step10_d;
  logic [NCH-1:0]           chg_q, chg_d;
  logic [RTW-1:0]           rpt_q, rpt_d;
  logic                     rpt_first_q, rpt_first_d;
  logic [CLW-1:0]           clr_cnt_q, clr_cnt_d;
  logic                     clr_q, clr_d;
  logic                     do_up, do_dn, hold_is_up;

  assign btn_raw = {BTN_SEL, BTN_DN, BTN_UP};

  for (genvar b = 0; b < NBTN; b++) begin : g_db
    btn_debounce #(.DBW(DBW), .DB_TIMEOUT(DB_TIMEOUT)) u_db (
      .clk      (CLK),
      .rst      (RST),
      .btn_n    (btn_raw[b]),
      .sync_lvl (sync_lvl[b]),
      .lvl      (lvl[b]),
      .press_pls(press[b]),
      .rel_pls  (rel[b])
    );
  end

  assign unused_sel = &{1'b0, rel[BTN_SEL_IDX], lvl[BTN_SEL_IDX]};

  // A button stays blocked after reset until it is seen released. A button held through reset therefore never acts.
  assign blk_d    = blk_q & ~sync_lvl;
  assign press_ok = press & ~blk_q;

  function automatic logic [CW:0] step_up(input logic [CW:0] c, input logic [CW:0] s, input logic [CW:0] u);
    logic [CW:0] sum;
    sum = c + s;
    if (WRAP != 0) return (sum > u) ? sum - (u + (CW+1)'(1)) : sum;
    return (sum > u) ? u : sum;
  endfunction

  function automatic logic [CW:0] step_dn(input logic [CW:0] c, input logic [CW:0] s, input logic [CW:0] u);
    if (c < s) return (WRAP != 0) ? c + u + (CW+1)'(1) - s : '0;
    return c - s;
  endfunction

  // FSM next state: step requests, repeat timer, chord toggle and channel select.
  always_comb begin
    state_d     = state_q;
    ch_sel_d    = ch_sel_q;
    step10_d    = step10_q;
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    do_up       = 1'b0;
    do_dn       = 1'b0;
    hold_is_up  = (state_q == ST_HOLD_UP);
    case (state_q)
      ST_IDLE: begin
        rpt_d       = '0;
        rpt_first_d = 1'b1;
        if (press_ok[BTN_UP_IDX] && press_ok[BTN_DN_IDX]) begin
          state_d = ST_CHORD;
        end else if (press_ok[BTN_UP_IDX]) begin
          do_up   = 1'b1;
          state_d = ST_HOLD_UP;
        end else if (press_ok[BTN_DN_IDX]) begin
          do_dn   = 1'b1;
          state_d = ST_HOLD_DN;
        end
        if (press_ok[BTN_SEL_IDX])
          ch_sel_d = (ch_sel_q == CSW'(NCH - 1)) ? '0 : ch_sel_q + CSW'(1);
      end
      ST_HOLD_UP, ST_HOLD_DN: begin
        if (hold_is_up ? rel[BTN_UP_IDX] : rel[BTN_DN_IDX]) begin
          state_d = ST_IDLE;
        end else if (hold_is_up ? press_ok[BTN_DN_IDX] : press_ok[BTN_UP_IDX]) begin
          state_d = ST_CHORD;
        end else if (rpt_q == (rpt_first_q ? RTW'(RPT_DLY - 1) : RTW'(RPT_PER - 1))) begin
          rpt_d       = '0;
          rpt_first_d = 1'b0;
          do_up       = hold_is_up;
          do_dn       = ~hold_is_up;
        end else begin
          rpt_d = rpt_q + RTW'(1);
        end
      end
      ST_CHORD: begin
        if (lvl[BTN_UP_IDX] && lvl[BTN_DN_IDX]) begin
          step10_d = ~step10_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-channel update: step the selected channel, then clamp every channel to its bound.
  // The step uses CW+1 bits so that the carry out of c+s is not lost.
  always_comb begin
    logic [CW:0] c1, u1, n1, s1;
    s1 = step10_q ? (CW+1)'(STEP_X10) : (CW+1)'(STEP_X1);
    c1 = '0;
    u1 = '0;
    n1 = '0;
    cnt_d = cnt_q;
    chg_d = '0;
    for (int i = 0; i < NCH; i++) begin
      c1 = {1'b0, cnt_q[i]};
      u1 = {1'b0, UBND[i*CW +: CW]};
      n1 = c1;
      if (CSW'(i) == ch_sel_q) begin
        if (do_up)      n1 = step_up(c1, s1, u1);
        else if (do_dn) n1 = step_dn(c1, s1, u1);
      end
      if (n1 > u1) n1 = u1;
      cnt_d[i] = n1[CW-1:0];
      chg_d[i] = (n1[CW-1:0] != cnt_q[i]);
    end
    clr_cnt_d = (|chg_d) ? CLW'(CLR_CYC)
              : ((clr_cnt_q != '0) ? clr_cnt_q - CLW'(1) : '0);
    clr_d     = (clr_cnt_d != '0);
  end

  // All state: the FSM, counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ch_sel_q    <= '0;
      step10_q    <= 1'b0;
      chg_q       <= '0;
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
      clr_cnt_q   <= '0;
      clr_q       <= 1'b0;
      blk_q       <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_sel_q    <= ch_sel_d;
      step10_q    <= step10_d;
      chg_q       <= chg_d;
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_q       <= clr_d;
      blk_q       <= blk_d;
    end
  end

  assign CNT     = cnt_q;
  assign CH_SEL  = ch_sel_q;
  assign STEP10  = step10_q;
  assign CHG     = chg_q;
  assign CLR_SEQ = clr_q;

endmodule
